// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller driving dual_port_ram (port A write, port B read); FIFO_ALMOST_FLAGS_EN adds almost_full/almost_empty.
// Read data is valid one cycle after an accepted read; writes when full and reads when empty are dropped and flagged.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH          = 8,
  parameter int ADDR_WIDTH          = 4,
  parameter int ALMOST_FULL_MARGIN  = 2,
  parameter int ALMOST_EMPTY_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  collision_err,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  output logic                  ram_we_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_din_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b,
  input  logic                  ram_collision
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] count_q;
  logic                wr_acc;
  logic                rd_acc;

  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  assign ram_we_a   = wr_acc;
  assign ram_addr_a = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_din_a  = wr_data;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = rd_ptr[ADDR_WIDTH-1:0];
  assign ram_din_b  = '0;
  // The RAM registers port B every cycle, so its output already holds the word at the pre-increment rd_ptr.
  assign rd_data    = ram_dout_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      rd_valid      <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      collision_err <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + ONE;
        2'b01:   count_q <= count_q - ONE;
        default: count_q <= count_q;
      endcase
      rd_valid      <= rd_acc;
      overflow      <= overflow | (wr_en & full);
      underflow     <= underflow | (rd_en & empty);
      collision_err <= collision_err | ram_collision;
    end
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [ADDR_WIDTH:0] AF_TH = (ADDR_WIDTH+1)'(DEPTH - ALMOST_FULL_MARGIN);
  localparam logic [ADDR_WIDTH:0] AE_TH = (ADDR_WIDTH+1)'(ALMOST_EMPTY_MARGIN);

  assign almost_full  = (count_q >= AF_TH);
  assign almost_empty = (count_q <= AE_TH);
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl with a behavioural registered-read dual-port RAM.
// Define FIFO_ALMOST_FLAGS_EN on both files to include the almost-flag scenario.
module tb_sync_fifo_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       rd_en;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
  logic       collision_err;
  logic       ram_we_a;
  logic [3:0] ram_addr_a;
  logic [7:0] ram_din_a;
  logic       ram_we_b;
  logic [3:0] ram_addr_b;
  logic [7:0] ram_din_b;
  logic [7:0] ram_dout_b;
  logic       ram_collision;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic       almost_full;
  logic       almost_empty;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [16];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    ram_dout_b <= mem[ram_addr_b];
  end

  sync_fifo_ctrl dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow),
    .collision_err(collision_err), .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a),
    .ram_din_a(ram_din_a), .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b),
    .ram_din_b(ram_din_b), .ram_dout_b(ram_dout_b), .ram_collision(ram_collision)
`ifdef FIFO_ALMOST_FLAGS_EN
    , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; ram_collision = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if ({empty, full, rd_valid} !== 3'b100) begin bad++; $display("FAIL reset_flags {empty,full,rd_valid}: got %b want 100", {empty, full, rd_valid}); end
    total++; if ({overflow, underflow, collision_err} !== 3'b000) begin bad++; $display("FAIL reset_errs: got %b want 000", {overflow, underflow, collision_err}); end
    total++; if ({ram_we_b, ram_din_b, ram_addr_a, ram_addr_b} !== 17'd0) begin bad++; $display("FAIL reset_ram_ports: got %h want 0", {ram_we_b, ram_din_b, ram_addr_a, ram_addr_b}); end
  endtask

  task automatic test_basic();
    logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = vals[i];
      step();
    end
    wr_en = 1'b0;
    total++; if (count !== 5'd3 || empty !== 1'b0) begin bad++; $display("FAIL basic_fill: count %0d empty %b want 3 0", count, empty); end
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      step();
      total++; if (rd_valid !== 1'b1 || rd_data !== vals[i]) begin bad++; $display("FAIL basic_read%0d: valid %b data %h want 1 %h", i, rd_valid, rd_data, vals[i]); end
      total++; if (count !== 5'(2 - i)) begin bad++; $display("FAIL basic_count%0d: got %0d want %0d", i, count, 2 - i); end
    end
    rd_en = 1'b0;
    step();
    total++; if (rd_valid !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL basic_end: valid %b empty %b want 0 1", rd_valid, empty); end
  endtask

  task automatic test_full_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
      if (i == 14) begin
        total++; if (full !== 1'b0) begin bad++; $display("FAIL full_early: got %b want 0 at count 15", full); end
      end
    end
    total++; if (full !== 1'b1 || count !== 5'd16) begin bad++; $display("FAIL full_set: full %b count %0d want 1 16", full, count); end
    wr_data = 8'hAA;
    step();
    wr_en = 1'b0;
    total++; if (overflow !== 1'b1 || count !== 5'd16) begin bad++; $display("FAIL overflow: ovf %b count %0d want 1 16", overflow, count); end
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      step();
      total++; if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin bad++; $display("FAIL full_drain%0d: valid %b data %h want 1 %h", i, rd_valid, rd_data, 8'(i)); end
    end
    rd_en = 1'b0;
    step();
    total++; if (empty !== 1'b1 || overflow !== 1'b1 || rd_valid !== 1'b0) begin bad++; $display("FAIL full_end: empty %b ovf %b valid %b want 1 1 0", empty, overflow, rd_valid); end
  endtask

  task automatic test_underflow();
    do_reset();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    total++; if (rd_valid !== 1'b0 || underflow !== 1'b1) begin bad++; $display("FAIL underflow: valid %b udf %b want 0 1", rd_valid, underflow); end
    total++; if (ram_addr_b !== 4'd0 || count !== 5'd0) begin bad++; $display("FAIL underflow_state: rd_addr %0d count %0d want 0 0", ram_addr_b, count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'h40 + 8'(i);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h45 + 8'(i);
      step();
      total++; if (rd_valid !== 1'b1 || rd_data !== 8'h40 + 8'(i) || count !== 5'd5) begin bad++; $display("FAIL b2b%0d: valid %b data %h count %0d want 1 %h 5", i, rd_valid, rd_data, count, 8'h40 + 8'(i)); end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    total++; if (ram_addr_a !== 4'd9 || ram_addr_b !== 4'd4) begin bad++; $display("FAIL b2b_wrap: wa %0d ra %0d want 9 4", ram_addr_a, ram_addr_b); end
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b1;
      step();
      total++; if (rd_valid !== 1'b1 || rd_data !== 8'h54 + 8'(i)) begin bad++; $display("FAIL b2b_drain%0d: valid %b data %h want 1 %h", i, rd_valid, rd_data, 8'h54 + 8'(i)); end
    end
    rd_en = 1'b0;
    step();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty: got %b want 1", empty); end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    wr_en = 1'b1; wr_data = 8'h77;
    step();
    wr_en = 1'b0; wr_data = 8'h66;
    step();
    wr_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    total++; if (rd_valid !== 1'b1 || count !== 5'd1) begin bad++; $display("FAIL mid_pre: valid %b count %0d want 1 1", rd_valid, count); end
    #2 rst = 1'b1;
    #1;
    total++; if (rd_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin bad++; $display("FAIL mid_rst: valid %b count %0d empty %b want 0 0 1", rd_valid, count, empty); end
    rd_en = 1'b0;
    step();
    rst = 1'b0;
    step();
    wr_en = 1'b1; wr_data = 8'h5A;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin bad++; $display("FAIL mid_after: valid %b data %h want 1 5a", rd_valid, rd_data); end
  endtask

  task automatic test_collision();
    do_reset();
    ram_collision = 1'b1;
    step();
    ram_collision = 1'b0;
    step();
    total++; if (collision_err !== 1'b1 || count !== 5'd0) begin bad++; $display("FAIL collision: err %b count %0d want 1 0", collision_err, count); end
    do_reset();
    total++; if (collision_err !== 1'b0) begin bad++; $display("FAIL collision_clear: got %b want 0", collision_err); end
  endtask

`ifdef FIFO_ALMOST_FLAGS_EN
  task automatic test_almost_flags();
    do_reset();
    total++; if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin bad++; $display("FAIL almost_reset: af %b ae %b want 0 1", almost_full, almost_empty); end
    for (int i = 0; i < 14; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
      if (i == 12) begin
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL almost_full13: got %b want 0", almost_full); end
      end
    end
    wr_en = 1'b0;
    total++; if (almost_full !== 1'b1 || count !== 5'd14) begin bad++; $display("FAIL almost_full14: af %b count %0d want 1 14", almost_full, count); end
    for (int i = 0; i < 12; i++) begin
      rd_en = 1'b1;
      step();
      if (i == 10) begin
        total++; if (almost_empty !== 1'b0 || count !== 5'd3) begin bad++; $display("FAIL almost_empty3: ae %b count %0d want 0 3", almost_empty, count); end
      end
    end
    rd_en = 1'b0;
    total++; if (almost_empty !== 1'b1 || count !== 5'd2) begin bad++; $display("FAIL almost_empty2: ae %b count %0d want 1 2", almost_empty, count); end
  endtask
`endif

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; ram_collision = 1'b0;
    test_reset();
    test_basic();
    test_full_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_mid_read();
    test_collision();
`ifdef FIFO_ALMOST_FLAGS_EN
    test_almost_flags();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock FIFO controller that sits directly upstream of dual_port_ram and drives it.
- Port A is the write port; port B is the read-only port.
- Owns the read/write pointers, occupancy count, full/empty flags and error flags.
- Presents a simple wr_en/rd_en FIFO interface to the datapath.
- Read data returns from the RAM's registered port-B output one cycle after an accepted read.

Parameters:
DATA_WIDTH, 8, word width; must match the RAM.
ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH entries.
ALMOST_FULL_MARGIN, 2, almost_full threshold margin (optional feature only).
ALMOST_EMPTY_MARGIN, 2, almost_empty threshold (optional feature only).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
wr_en  in  1  write request.
wr_data  in  DATA_WIDTH  write word.
full  out  1  count == DEPTH.
rd_en  in  1  read request.
rd_valid  out  1  rd_data is valid this cycle.
rd_data  out  DATA_WIDTH  read word; passed through from ram_dout_b.
empty  out  1  count == 0.
count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH.
overflow  out  1  sticky: wr_en was asserted while full.
underflow  out  1  sticky: rd_en was asserted while empty.
collision_err  out  1  sticky: ram_collision was seen high.
ram_we_a  out  1  RAM port-A write enable.
ram_addr_a  out  ADDR_WIDTH  RAM port-A address = wr_ptr[ADDR_WIDTH-1:0].
ram_din_a  out  DATA_WIDTH  RAM port-A data = wr_data.
ram_we_b  out  1  tied 0.
ram_addr_b  out  ADDR_WIDTH  RAM port-B address = rd_ptr[ADDR_WIDTH-1:0].
ram_din_b  out  DATA_WIDTH  tied 0.
ram_dout_b  in  DATA_WIDTH  RAM port-B registered read data.
ram_collision  in  1  RAM collision flag.

Behaviour:
- Reset (async assert, synchronous release):
  - wr_ptr, rd_ptr and count = 0.
  - empty = 1; full = 0; rd_valid = 0.
  - overflow, underflow and collision_err = 0.
  - RAM contents are not cleared. Data held before reset is discarded.
  - A reset during a pending read kills rd_valid.
- Pointers: ADDR_WIDTH+1 bits each. The MSB is the wrap bit; pointers increment modulo 2*DEPTH.
- Accept rules:
  - wr_acc = wr_en & ~full.
  - rd_acc = rd_en & ~empty.
  - There is no write pass-through when full and no read when empty, even if the other side is active.
- RAM write: ram_we_a = wr_acc (combinational). Data is written at the same edge that wr_ptr increments.
- Read latency:
  - rd_acc at edge k increments rd_ptr and sets rd_valid = 1 for cycle k..k+1.
  - rd_data = ram_dout_b is the word at the pre-increment rd_ptr.
  - rd_valid is registered: rd_valid <= rd_acc.
- count update:
  - +1 on wr_acc only; -1 on rd_acc only.
  - Unchanged on both or neither.
- full and empty are decoded from count.
  - full also equals: pointer low bits equal and MSBs differ.
  - empty also equals: pointers equal.
- Hazards:
  - Read and write addresses can only coincide when empty or full, so no same-address read/write ever occurs.
  - A word written at edge k is readable at edge k+1 at the earliest, because empty deasserts after edge k.
- Errors:
  - overflow sets on wr_en & full.
  - underflow sets on rd_en & empty.
  - collision_err sets on ram_collision.
  - All three are sticky until rst.
  - Rejected requests do not change any state other than these flags.

Optional Feature:
FIFO_ALMOST_FLAGS_EN
- Defined: adds ports almost_full (out, 1) = count >= DEPTH-ALMOST_FULL_MARGIN, and almost_empty (out, 1) = count <= ALMOST_EMPTY_MARGIN. Both are decoded from the count register; reset values are almost_full = 0 and almost_empty = 1.
- Undefined: the ports and logic are absent; the margin parameters are unused.

Test Plan:
All scenarios use defaults (DEPTH = 16).
1. Reset, write 0x11, 0x22, 0x33, then read 3 times -> rd_valid one cycle after each rd_en; rd_data = 0x11, 0x22, 0x33; count 3->0; empty = 1 at end.
2. Write 16 words 0x00..0x0F -> full = 1, count = 16. A 17th write with 0xAA -> overflow = 1, count stays 16. Reading all 16 gives 0x00..0x0F with no 0xAA.
3. From empty, rd_en for 1 cycle -> rd_valid stays 0, underflow = 1, rd_ptr unchanged.
4. With count = 5, simultaneous wr_en and rd_en for 20 cycles -> count stays 5, and pointers wrap past 15. Output order matches input order across the wrap.
5. Write one word, assert rst mid-stream while rd_en is high -> rd_valid = 0, count = 0 and empty = 1 immediately. A later write of 0x5A followed by a read returns 0x5A.
6. With FIFO_ALMOST_FLAGS_EN defined, fill to 14 -> almost_full = 1 at count 14, not at 13. Drain to 2 -> almost_empty = 1 at count 2, not at 3.
